// File: rtl/hit_resolver_pkg.sv
// Shared definitions for the hit resolver: player states,
// result codes, hitbox field layout and a saturating subtract.
package hit_resolver_pkg;

    localparam logic [3:0] S_IDLE           = 4'd0;
    localparam logic [3:0] S_MOVEFORWARDS   = 4'd1;
    localparam logic [3:0] S_MOVEBACKWARDS  = 4'd2;
    localparam logic [3:0] S_B_ATTACK_START = 4'd3;
    localparam logic [3:0] S_B_ATTACK_END   = 4'd4;
    localparam logic [3:0] S_B_ATTACK_PULL  = 4'd5;
    localparam logic [3:0] S_D_ATTACK_START = 4'd6;
    localparam logic [3:0] S_D_ATTACK_END   = 4'd7;
    localparam logic [3:0] S_D_ATTACK_PULL  = 4'd8;
    localparam logic [3:0] S_HITSTUN        = 4'd9;
    localparam logic [3:0] S_BLOCKSTUN      = 4'd10;

    localparam logic [1:0] HF_NONE  = 2'b00;
    localparam logic [1:0] HF_BASIC = 2'b01;
    localparam logic [1:0] HF_DIR   = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Box packing is {x1,x2,y1,y2}, 10 bits per coordinate
    localparam int COORD_W    = 10;
    localparam int BOX_W      = 40;
    localparam int BOX_X1_LSB = 30;
    localparam int BOX_X2_LSB = 20;
    localparam int BOX_Y1_LSB = 10;
    localparam int BOX_Y2_LSB = 0;

    function automatic logic is_stunned(input logic [3:0] s);
        return (s == S_HITSTUN) || (s == S_BLOCKSTUN);
    endfunction

    function automatic logic [6:0] sat_sub(input logic [6:0] h,
                                           input logic [6:0] d);
        return (h <= d) ? 7'd0 : h - d;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational inclusive rectangle overlap test; each box's
// coordinate pairs are ordered to (min,max) before comparing.
module box_overlap
    import hit_resolver_pkg::*;
(
    input  logic [BOX_W-1:0] a,
    input  logic [BOX_W-1:0] b,
    output logic             hit
);

    logic [COORD_W-1:0] ax1, ax2, ay1, ay2;
    logic [COORD_W-1:0] bx1, bx2, by1, by2;
    logic [COORD_W-1:0] axl, axh, ayl, ayh;
    logic [COORD_W-1:0] bxl, bxh, byl, byh;

    assign ax1 = a[BOX_X1_LSB +: COORD_W];
    assign ax2 = a[BOX_X2_LSB +: COORD_W];
    assign ay1 = a[BOX_Y1_LSB +: COORD_W];
    assign ay2 = a[BOX_Y2_LSB +: COORD_W];
    assign bx1 = b[BOX_X1_LSB +: COORD_W];
    assign bx2 = b[BOX_X2_LSB +: COORD_W];
    assign by1 = b[BOX_Y1_LSB +: COORD_W];
    assign by2 = b[BOX_Y2_LSB +: COORD_W];

    // Order each pair so swapped corners still describe the same box
    always_comb begin
        axl = (ax1 < ax2) ? ax1 : ax2;
        axh = (ax1 < ax2) ? ax2 : ax1;
        ayl = (ay1 < ay2) ? ay1 : ay2;
        ayh = (ay1 < ay2) ? ay2 : ay1;
        bxl = (bx1 < bx2) ? bx1 : bx2;
        bxh = (bx1 < bx2) ? bx2 : bx1;
        byl = (by1 < by2) ? by1 : by2;
        byh = (by1 < by2) ? by2 : by1;
        hit = (axl <= bxh) && (bxl <= axh) &&
              (ayl <= byh) && (byl <= ayh);
    end

endmodule

// File: rtl/hit_resolver.sv
// Resolves attack/hurtbox contact between two players into hit
// pulses, health, game over and winner. CHIP_DAMAGE_EN: block chip.
module hit_resolver
    import hit_resolver_pkg::*;
#(
    parameter int MAX_HEALTH = 100,
    parameter int DMG_BASIC  = 8,
    parameter int DMG_DIR    = 12,
    parameter int DMG_CHIP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       p1_state,
    input  logic [3:0]       p2_state,
    input  logic [BOX_W-1:0] p1_basic_box,
    input  logic [BOX_W-1:0] p2_basic_box,
    input  logic [BOX_W-1:0] p1_dir_box,
    input  logic [BOX_W-1:0] p2_dir_box,
    input  logic [BOX_W-1:0] p1_hurt_box,
    input  logic [BOX_W-1:0] p2_hurt_box,
    output logic [1:0]       p1_hitflag,
    output logic [1:0]       p2_hitflag,
    output logic [6:0]       p1_health,
    output logic [6:0]       p2_health,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam logic [6:0] HP_INIT = 7'(MAX_HEALTH);
    localparam logic [6:0] D_BASIC = 7'(DMG_BASIC);
    localparam logic [6:0] D_DIR   = 7'(DMG_DIR);
`ifdef CHIP_DAMAGE_EN
    localparam logic [6:0] D_CHIP  = 7'(DMG_CHIP);
`else
    // A block absorbs the whole hit
    localparam logic [6:0] D_CHIP  = 7'(0 * DMG_CHIP);
`endif

    logic ov_p1b, ov_p1d, ov_p2b, ov_p2d;
    logic p1_bact, p1_dact, p2_bact, p2_dact;
    logic p1_on, p2_on;
    logic p1_landed, p2_landed;
    logic [1:0] p1_flag_d, p2_flag_d;
    logic [6:0] p1_dmg, p2_dmg;

    box_overlap u_p1b (.a(p1_basic_box), .b(p2_hurt_box), .hit(ov_p1b));
    box_overlap u_p1d (.a(p1_dir_box),   .b(p2_hurt_box), .hit(ov_p1d));
    box_overlap u_p2b (.a(p2_basic_box), .b(p1_hurt_box), .hit(ov_p2b));
    box_overlap u_p2d (.a(p2_dir_box),   .b(p1_hurt_box), .hit(ov_p2d));

    // Gate boxes by attack phase, then pick flag and damage per victim
    always_comb begin
        p1_bact = ov_p1b && (p1_state == S_B_ATTACK_END);
        p1_dact = ov_p1d && (p1_state == S_D_ATTACK_END);
        p2_bact = ov_p2b && (p2_state == S_B_ATTACK_END);
        p2_dact = ov_p2d && (p2_state == S_D_ATTACK_END);
        p1_on = (p1_bact || p1_dact) && !p1_landed &&
                !is_stunned(p2_state) && !game_over;
        p2_on = (p2_bact || p2_dact) && !p2_landed &&
                !is_stunned(p1_state) && !game_over;
        p2_flag_d = !p1_on ? HF_NONE : (p1_dact ? HF_DIR : HF_BASIC);
        p1_flag_d = !p2_on ? HF_NONE : (p2_dact ? HF_DIR : HF_BASIC);
        p2_dmg = (p2_state == S_MOVEBACKWARDS) ? D_CHIP :
                 (p1_dact ? D_DIR : D_BASIC);
        p1_dmg = (p1_state == S_MOVEBACKWARDS) ? D_CHIP :
                 (p2_dact ? D_DIR : D_BASIC);
    end

    // One-shot latches so a held END state lands only once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_landed <= 1'b0;
            p2_landed <= 1'b0;
        end else begin
            if (p1_on)
                p1_landed <= 1'b1;
            else if (p1_state != S_B_ATTACK_END &&
                     p1_state != S_D_ATTACK_END)
                p1_landed <= 1'b0;
            if (p2_on)
                p2_landed <= 1'b1;
            else if (p2_state != S_B_ATTACK_END &&
                     p2_state != S_D_ATTACK_END)
                p2_landed <= 1'b0;
        end
    end

    // Register hit pulses and apply damage on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_hitflag <= HF_NONE;
            p2_hitflag <= HF_NONE;
            p1_health  <= HP_INIT;
            p2_health  <= HP_INIT;
        end else begin
            p1_hitflag <= p1_flag_d;
            p2_hitflag <= p2_flag_d;
            if (p2_on)
                p1_health <= sat_sub(p1_health, p1_dmg);
            if (p1_on)
                p2_health <= sat_sub(p2_health, p2_dmg);
        end
    end

    // Latch the end of the match one edge after a health hits zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else if (!game_over) begin
            if (p1_health == 7'd0 && p2_health == 7'd0) begin
                game_over <= 1'b1;
                winner    <= WIN_DRAW;
            end else if (p2_health == 7'd0) begin
                game_over <= 1'b1;
                winner    <= WIN_P1;
            end else if (p1_health == 7'd0) begin
                game_over <= 1'b1;
                winner    <= WIN_P2;
            end
        end
    end

endmodule
